// File: rtl/branch_pkg.sv
// Shared definitions for the branch control block.
//  - br_cond encodings used by decode and the taken evaluator
//  - FSM state encoding for the start-up / run / flush / halt sequencer
//  - width of the shared restart/flush cycle counter
package branch_pkg;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_EQZ    = 2'b01;
  localparam logic [1:0] COND_NEZ    = 2'b10;
  localparam logic [1:0] COND_NEG    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  // One counter serves both the restart and flush phases; cycle counts up to 256.
  localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch resolution.
//  Evaluates the branch condition against the ALU flags and forms the
//  destination: either the absolute register value or pc_cur plus the
//  sign-extended relative offset (wrapping modulo 2^PC_WIDTH).
// Ports:
//  br_cond   in  2          condition select
//  br_abs    in  1          1: absolute target, 0: pc-relative
//  br_offset in  OFF_WIDTH  signed relative offset
//  br_reg    in  PC_WIDTH   absolute target
//  pc_cur    in  PC_WIDTH   pc of the branch instruction
//  flag_zero in  1          ALU zero flag
//  flag_neg  in  1          ALU negative flag
//  taken     out 1          condition satisfied
//  target    out PC_WIDTH   computed destination
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int PC_WIDTH  = 16,
  parameter int OFF_WIDTH = 8
) (
  input  logic [1:0]           br_cond,
  input  logic                 br_abs,
  input  logic [OFF_WIDTH-1:0] br_offset,
  input  logic [PC_WIDTH-1:0]  br_reg,
  input  logic [PC_WIDTH-1:0]  pc_cur,
  input  logic                 flag_zero,
  input  logic                 flag_neg,
  output logic                 taken,
  output logic [PC_WIDTH-1:0]  target
);

  logic [PC_WIDTH-1:0] offset_ext_s;

  // Condition evaluation against ALU flags.
  always_comb begin
    taken = 1'b0;
    case (br_cond)
      COND_ALWAYS: taken = 1'b1;
      COND_EQZ:    taken = flag_zero;
      COND_NEZ:    taken = ~flag_zero;
      COND_NEG:    taken = flag_neg;
      default:     taken = 1'b0;
    endcase
  end

  // Sign-extend the offset; the add naturally wraps at PC_WIDTH bits.
  assign offset_ext_s = {{(PC_WIDTH-OFF_WIDTH){br_offset[OFF_WIDTH-1]}}, br_offset};

  // Target select: absolute register or pc-relative sum.
  always_comb begin
    if (br_abs) begin
      target = br_reg;
    end else begin
      target = pc_cur + offset_ext_s;
    end
  end

endmodule

// File: rtl/branch_control.sv
// Branch / restart / flush control feeding next_pc_logic.
//  Sequences start-up (multi-cycle restart), normal run, post-branch flush
//  and halt, and resolves branches through branch_target_calc. Every output
//  is a register whose value reflects the state being entered, so the branch
//  pulse lands one clock after the sampled br_valid and coincides with the
//  first flush cycle.
// Ports:
//  clock, reset              rising-edge clock, synchronous active-high reset
//  start, halt_req           sequencing requests
//  br_valid, br_cond, br_abs, br_offset, br_reg, pc_cur   decoded branch
//  flag_zero, flag_neg       ALU flags
//  branch, target            one-cycle load pulse and held destination
//  restart, flush, halted    sequencing status to the fetch path
module branch_control
  import branch_pkg::*;
#(
  parameter int PC_WIDTH       = 16,
  parameter int OFF_WIDTH      = 8,
  parameter int RESTART_CYCLES = 2,
  parameter int FLUSH_CYCLES   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 br_valid,
  input  logic [1:0]           br_cond,
  input  logic                 br_abs,
  input  logic [OFF_WIDTH-1:0] br_offset,
  input  logic [PC_WIDTH-1:0]  br_reg,
  input  logic [PC_WIDTH-1:0]  pc_cur,
  input  logic                 flag_zero,
  input  logic                 flag_neg,
  output logic                 branch,
  output logic [PC_WIDTH-1:0]  target,
  output logic                 restart,
  output logic                 flush,
  output logic                 halted
);

  localparam logic [CNT_WIDTH-1:0] RESTART_LAST = CNT_WIDTH'(RESTART_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] FLUSH_LAST   = CNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t               state_r, state_next_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
  logic                 branch_fire_s;
  logic                 taken_s;
  logic [PC_WIDTH-1:0]  calc_target_s;
  logic                 branch_r, restart_r, flush_r, halted_r;
  logic [PC_WIDTH-1:0]  target_r;

  branch_target_calc #(
    .PC_WIDTH  (PC_WIDTH),
    .OFF_WIDTH (OFF_WIDTH)
  ) u_calc (
    .br_cond   (br_cond),
    .br_abs    (br_abs),
    .br_offset (br_offset),
    .br_reg    (br_reg),
    .pc_cur    (pc_cur),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .taken     (taken_s),
    .target    (calc_target_s)
  );

  // Next-state, counter and branch-fire decision.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    branch_fire_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_next_s = ST_RESTART;
          cnt_next_s   = {CNT_WIDTH{1'b0}};
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RESTART: begin
        // halt_req is deliberately not looked at until RUN.
        if (cnt_r == RESTART_LAST) begin
          state_next_s = ST_RUN;
          cnt_next_s   = {CNT_WIDTH{1'b0}};
        end else begin
          cnt_next_s   = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        // halt_req wins over a taken branch in the same cycle.
        if (halt_req) begin
          state_next_s = ST_HALTED;
        end else if (br_valid && taken_s) begin
          branch_fire_s = 1'b1;
          state_next_s  = ST_FLUSH;
          cnt_next_s    = {CNT_WIDTH{1'b0}};
        end else begin
          state_next_s  = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // br_valid is squashed here; only the final cycle looks at halt_req.
        if (cnt_r == FLUSH_LAST) begin
          cnt_next_s = {CNT_WIDTH{1'b0}};
          if (halt_req) begin
            state_next_s = ST_HALTED;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          cnt_next_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs derived from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_WIDTH{1'b0}};
      branch_r  <= 1'b0;
      target_r  <= {PC_WIDTH{1'b0}};
      restart_r <= 1'b1;
      flush_r   <= 1'b0;
      halted_r  <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      branch_r  <= branch_fire_s;
      if (branch_fire_s) begin
        target_r <= calc_target_s;
      end else begin
        target_r <= target_r;
      end
      restart_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_RESTART);
      flush_r   <= (state_next_s == ST_FLUSH);
      halted_r  <= (state_next_s == ST_IDLE) || (state_next_s == ST_HALTED);
    end
  end

  assign branch  = branch_r;
  assign target  = target_r;
  assign restart = restart_r;
  assign flush   = flush_r;
  assign halted  = halted_r;

endmodule

// File: tb/tb_branch_control.sv
// Directed bench for branch_control: a table of branch vectors applied in RUN,
// plus hand-written sequences for start-up, halt priority, flush squashing,
// halt on the last flush cycle and reset during FLUSH.
module tb_branch_control;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        br_valid;
  logic [1:0]  br_cond;
  logic        br_abs;
  logic [7:0]  br_offset;
  logic [15:0] br_reg;
  logic [15:0] pc_cur;
  logic        flag_zero;
  logic        flag_neg;
  logic        branch;
  logic [15:0] target;
  logic        restart;
  logic        flush;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  cond;
    logic        abs_sel;
    logic [7:0]  off;
    logic [15:0] reg_val;
    logic [15:0] pc;
    logic        z;
    logic        n;
    logic        exp_br;
    logic [15:0] exp_tgt;
  } vec_t;

  vec_t vecs [10];

  branch_control dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .halt_req  (halt_req),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_abs    (br_abs),
    .br_offset (br_offset),
    .br_reg    (br_reg),
    .pc_cur    (pc_cur),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .branch    (branch),
    .target    (target),
    .restart   (restart),
    .flush     (flush),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%04h required=0x%04h", name, act, exp);
    end
  endtask

  task automatic drive_br(input logic v, input logic [1:0] c, input logic a,
                          input logic [7:0] o, input logic [15:0] r,
                          input logic [15:0] p, input logic z, input logic n);
    br_valid  = v;
    br_cond   = c;
    br_abs    = a;
    br_offset = o;
    br_reg    = r;
    pc_cur    = p;
    flag_zero = z;
    flag_neg  = n;
  endtask

  // start pulse from IDLE/HALTED: restart high two cycles, then RUN.
  task automatic startup(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_rs1_restart"}, {15'd0, restart}, 16'd1);
    check({tag, "_rs1_halted"},  {15'd0, halted},  16'd0);
    tick();
    check({tag, "_rs2_restart"}, {15'd0, restart}, 16'd1);
    tick();
    check({tag, "_run_restart"}, {15'd0, restart}, 16'd0);
    check({tag, "_run_halted"},  {15'd0, halted},  16'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    halt_req = 1'b0;
    drive_br(1'b0, 2'b00, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);

    vecs[0] = '{2'b00, 1'b0, 8'h06, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h000A};
    vecs[1] = '{2'b01, 1'b0, 8'h10, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h000A};
    vecs[2] = '{2'b01, 1'b1, 8'h00, 16'h0008, 16'h0200, 1'b1, 1'b0, 1'b1, 16'h0008};
    vecs[3] = '{2'b00, 1'b0, 8'h02, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[4] = '{2'b00, 1'b0, 8'hFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF};
    vecs[5] = '{2'b10, 1'b0, 8'h80, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b1, 16'h0F80};
    vecs[6] = '{2'b10, 1'b1, 8'h00, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0F80};
    vecs[7] = '{2'b11, 1'b1, 8'h00, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234};
    vecs[8] = '{2'b11, 1'b0, 8'h01, 16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h1234};
    vecs[9] = '{2'b00, 1'b0, 8'h7F, 16'h0000, 16'h7FF0, 1'b0, 1'b1, 1'b1, 16'h806F};

    // Reset held three cycles.
    tick(); tick(); tick();
    check("rst_restart", {15'd0, restart}, 16'd1);
    check("rst_halted",  {15'd0, halted},  16'd1);
    check("rst_branch",  {15'd0, branch},  16'd0);
    check("rst_flush",   {15'd0, flush},   16'd0);
    check("rst_target",  target,           16'h0000);
    reset = 1'b0;
    tick();
    check("idle_restart", {15'd0, restart}, 16'd1);
    startup("boot");

    // Table of branches applied from RUN.
    for (int i = 0; i < 10; i++) begin
      drive_br(1'b1, vecs[i].cond, vecs[i].abs_sel, vecs[i].off, vecs[i].reg_val,
               vecs[i].pc, vecs[i].z, vecs[i].n);
      tick();
      drive_br(1'b0, 2'b00, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
      check($sformatf("vec%0d_branch", i), {15'd0, branch}, {15'd0, vecs[i].exp_br});
      check($sformatf("vec%0d_flush", i),  {15'd0, flush},  {15'd0, vecs[i].exp_br});
      check($sformatf("vec%0d_target", i), target, vecs[i].exp_tgt);
      check($sformatf("vec%0d_restart", i), {15'd0, restart}, 16'd0);
      tick();
      check($sformatf("vec%0d_post_branch", i), {15'd0, branch}, 16'd0);
      check($sformatf("vec%0d_post_flush", i),  {15'd0, flush},  16'd0);
    end

    // start is ignored while running.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_restart", {15'd0, restart}, 16'd0);
    check("run_start_halted",  {15'd0, halted},  16'd0);

    // halt_req beats a taken branch in the same cycle.
    halt_req = 1'b1;
    drive_br(1'b1, 2'b00, 1'b1, 8'h00, 16'h3333, 16'h0000, 1'b0, 1'b0);
    tick();
    halt_req = 1'b0;
    drive_br(1'b0, 2'b00, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("halt_branch",  {15'd0, branch},  16'd0);
    check("halt_halted",  {15'd0, halted},  16'd1);
    check("halt_restart", {15'd0, restart}, 16'd0);
    check("halt_target",  target,           16'h806F);
    tick();
    check("halted_stays", {15'd0, halted},  16'd1);
    startup("resume");

    // halt_req during RESTART is ignored.
    halt_req = 1'b1;
    tick();
    check("halt_in_run_again", {15'd0, halted}, 16'd1);
    halt_req = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    check("restart_ignores_halt", {15'd0, halted}, 16'd0);
    check("restart_done",         {15'd0, restart}, 16'd0);

    // br_valid during FLUSH is squashed.
    drive_br(1'b1, 2'b00, 1'b1, 8'h00, 16'h0100, 16'h0000, 1'b0, 1'b0);
    tick();
    check("sq_branch1", {15'd0, branch}, 16'd1);
    check("sq_target1", target, 16'h0100);
    drive_br(1'b1, 2'b00, 1'b1, 8'h00, 16'h5555, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_br(1'b0, 2'b00, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("sq_branch2", {15'd0, branch}, 16'd0);
    check("sq_target2", target, 16'h0100);
    check("sq_flush2",  {15'd0, flush},  16'd0);

    // halt_req on the last flush cycle goes to HALTED.
    drive_br(1'b1, 2'b00, 1'b0, 8'h10, 16'h0000, 16'h0020, 1'b0, 1'b0);
    tick();
    drive_br(1'b0, 2'b00, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("fh_flush", {15'd0, flush}, 16'd1);
    check("fh_target", target, 16'h0030);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("fh_halted", {15'd0, halted}, 16'd1);
    check("fh_flush_off", {15'd0, flush}, 16'd0);
    startup("fh");

    // Reset asserted while in FLUSH.
    drive_br(1'b1, 2'b00, 1'b1, 8'h00, 16'h0777, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_br(1'b0, 2'b00, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("rf_flush", {15'd0, flush}, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rf_restart", {15'd0, restart}, 16'd1);
    check("rf_flush0",  {15'd0, flush},   16'd0);
    check("rf_branch",  {15'd0, branch},  16'd0);
    check("rf_halted",  {15'd0, halted},  16'd1);
    check("rf_target",  target,           16'h0000);
    tick();
    check("rf_idle_restart", {15'd0, restart}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
